// File: rtl/ll_seq_ctrl.sv
// Line-length sequencer: gates samples into the LL datapath (active-low enable), frames them into
// sub-windows, captures each LL result and raises a debounced over-threshold detection flag.
`timescale 1ns/1ps
module ll_seq_ctrl #(
  parameter int DATA_W   = 16,
  parameter int LL_W     = 25,
  parameter int WIN_LEN  = 50,
  parameter int SUB_WINS = 5,
  parameter int DET_CNT  = 3,
  parameter int TMO      = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     smp_valid,
  input  logic signed [DATA_W-1:0] smp_in,
  input  logic signed [LL_W-1:0]   threshold,
  output logic signed [DATA_W-1:0] dp_din,
  output logic                     dp_en,
  output logic                     dp_rst,
  input  logic                     dp_valid,
  input  logic signed [LL_W-1:0]   dp_dout,
  output logic signed [LL_W-1:0]   ll_out,
  output logic                     ll_valid,
  output logic                     detect,
  output logic                     busy,
  output logic [1:0]               err
);

  localparam int SMP_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WIN_W = $clog2(SUB_WINS + 1);
  localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int HIT_W = $clog2(DET_CNT + 1);

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WIN_LEN - 1);
  localparam logic [WIN_W-1:0] WIN_FULL = WIN_W'(SUB_WINS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
  localparam logic [HIT_W-1:0] HIT_FULL = HIT_W'(DET_CNT);

  typedef enum logic [1:0] {IDLE, CLR, RUN, WAIT} state_t;

  function automatic logic [WIN_W-1:0] win_sat_inc(input logic [WIN_W-1:0] v);
    return (v == WIN_FULL) ? v : v + WIN_W'(1);
  endfunction

  function automatic logic [HIT_W-1:0] hit_sat_inc(input logic [HIT_W-1:0] v);
    return (v == HIT_FULL) ? v : v + HIT_W'(1);
  endfunction

  state_t                     state_q, state_d;
  logic [SMP_W-1:0]           smp_cnt_q, smp_cnt_d;
  logic [WIN_W-1:0]           win_cnt_q, win_cnt_d;
  logic [TMO_W-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic [HIT_W-1:0]           hit_cnt_q, hit_cnt_d;
  logic                       skid_full_q, skid_full_d;
  logic signed [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic signed [DATA_W-1:0]   dp_din_q, dp_din_d;
  logic                       dp_en_q, dp_en_d;
  logic signed [LL_W-1:0]     ll_out_q, ll_out_d;
  logic                       ll_valid_q, ll_valid_d;
  logic                       detect_q, detect_d;
  logic [1:0]                 err_q, err_d;
  logic                       issue;
  logic signed [DATA_W-1:0]   issue_data;
  logic [WIN_W-1:0]           win_inc;
  logic [HIT_W-1:0]           hit_nxt;

  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    win_cnt_d   = win_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    dp_din_d    = dp_din_q;
    dp_en_d     = 1'b1;
    ll_out_d    = ll_out_q;
    ll_valid_d  = 1'b0;
    detect_d    = detect_q;
    err_d       = err_q;
    issue       = 1'b0;
    issue_data  = smp_in;
    win_inc     = win_sat_inc(win_cnt_q);
    hit_nxt     = hit_cnt_q;

    // Samples arriving while the datapath is not accepting are parked in a single-entry skid.
    if ((state_q == CLR || state_q == WAIT) && smp_valid) begin
      if (skid_full_q) begin
        err_d[0] = 1'b1;
      end else begin
        skid_full_d = 1'b1;
        skid_data_d = smp_in;
      end
    end

    case (state_q)
      IDLE: begin
        smp_cnt_d = '0;
        win_cnt_d = '0;
        tmo_cnt_d = '0;
        if (start) begin
          state_d = CLR;
          err_d   = 2'b00;
        end
      end
      CLR: state_d = RUN;
      RUN: begin
        if (skid_full_q) begin
          issue       = 1'b1;
          issue_data  = skid_data_q;
          skid_full_d = smp_valid;
          if (smp_valid) skid_data_d = smp_in;
        end else if (smp_valid) begin
          issue = 1'b1;
        end
        if (issue) begin
          dp_din_d = issue_data;
          dp_en_d  = 1'b0;
          if (smp_cnt_q == SMP_LAST) begin
            smp_cnt_d = '0;
            win_cnt_d = win_inc;
            if (win_inc == WIN_FULL) begin
              state_d   = WAIT;
              tmo_cnt_d = '0;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
      end
      WAIT: begin
        if (dp_valid) begin
          ll_out_d   = dp_dout;
          ll_valid_d = 1'b1;
          hit_nxt    = (dp_dout > threshold) ? hit_sat_inc(hit_cnt_q) : '0;
          hit_cnt_d  = hit_nxt;
          detect_d   = (hit_nxt == HIT_FULL);
          state_d    = RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d[1] = 1'b1;
          state_d  = RUN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything else but keeps the error history and last LL result.
    if (stop) begin
      state_d     = IDLE;
      smp_cnt_d   = '0;
      win_cnt_d   = '0;
      tmo_cnt_d   = '0;
      hit_cnt_d   = '0;
      skid_full_d = 1'b0;
      dp_din_d    = dp_din_q;
      dp_en_d     = 1'b1;
      ll_out_d    = ll_out_q;
      ll_valid_d  = 1'b0;
      detect_d    = 1'b0;
      err_d       = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      smp_cnt_q   <= '0;
      win_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      dp_din_q    <= '0;
      dp_en_q     <= 1'b1;
      ll_out_q    <= '0;
      ll_valid_q  <= 1'b0;
      detect_q    <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      win_cnt_q   <= win_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      dp_din_q    <= dp_din_d;
      dp_en_q     <= dp_en_d;
      ll_out_q    <= ll_out_d;
      ll_valid_q  <= ll_valid_d;
      detect_q    <= detect_d;
      err_q       <= err_d;
    end
  end

  assign dp_din   = dp_din_q;
  assign dp_en    = dp_en_q;
  assign dp_rst   = (state_q == IDLE) || (state_q == CLR);
  assign busy     = (state_q != IDLE);
  assign ll_out   = ll_out_q;
  assign ll_valid = ll_valid_q;
  assign detect   = detect_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ll_seq_ctrl.sv
// Directed bench for ll_seq_ctrl: drives inputs on the falling edge, samples outputs there too.
`timescale 1ns/1ps
module tb_ll_seq_ctrl;
  localparam int DATA_W = 16;
  localparam int LL_W   = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, start, stop, smp_valid, dp_valid;
  logic signed [DATA_W-1:0] smp_in;
  logic signed [LL_W-1:0]   threshold, dp_dout;
  logic signed [DATA_W-1:0] dp_din;
  logic                     dp_en, dp_rst, ll_valid, detect, busy;
  logic signed [LL_W-1:0]   ll_out;
  logic [1:0]               err;

  int n_tests = 0;
  int n_fail  = 0;
  int en_lo   = 0;
  int llv_cnt = 0;

  ll_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .smp_valid(smp_valid), .smp_in(smp_in), .threshold(threshold),
    .dp_din(dp_din), .dp_en(dp_en), .dp_rst(dp_rst),
    .dp_valid(dp_valid), .dp_dout(dp_dout),
    .ll_out(ll_out), .ll_valid(ll_valid), .detect(detect),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(negedge clk);
    if (dp_en === 1'b0) en_lo++;
    if (ll_valid === 1'b1) llv_cnt++;
  endtask

  task automatic send_smp(input int v);
    smp_valid = 1'b1;
    smp_in    = DATA_W'(v);
    tick();
    smp_valid = 1'b0;
  endtask

  // Ends on the falling edge right after the last sample was accepted.
  task automatic send_n(input int n, input int first, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap - 1) tick();
      send_smp(first + i);
    end
  endtask

  // Datapath model: result valid three cycles after the closing sample was accepted.
  task automatic dp_resp(input int val);
    tick();
    tick();
    dp_valid = 1'b1;
    dp_dout  = LL_W'(val);
    tick();
    dp_valid = 1'b0;
  endtask

  task automatic restart();
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; smp_valid = 1'b0; smp_in = '0;
    threshold = LL_W'(1000); dp_valid = 1'b0; dp_dout = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({dp_en, dp_rst, busy, detect, ll_valid, err} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 1100000", {dp_en, dp_rst, busy, detect, ll_valid, err});
    end
    n_tests++;
    if (dp_din !== '0 || ll_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got dp_din=%0d ll_out=%0d want 0 0", dp_din, ll_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    int exp_ll;
    exp_ll = 0;
    for (int k = 2; k <= 250; k++) exp_ll += (k > k - 1) ? k - (k - 1) : (k - 1) - k;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({busy, dp_rst} !== 2'b11) begin
      n_fail++; $display("FAIL clr_state: got busy,dp_rst=%b want 11", {busy, dp_rst});
    end
    tick();
    n_tests++;
    if ({busy, dp_rst, dp_en} !== 3'b101) begin
      n_fail++; $display("FAIL run_state: got busy,dp_rst,dp_en=%b want 101", {busy, dp_rst, dp_en});
    end
    en_lo = 0; llv_cnt = 0;
    send_n(250, 1, 4);
    n_tests++;
    if (llv_cnt != 0) begin
      n_fail++; $display("FAIL fill_no_llv: got %0d pulses want 0", llv_cnt);
    end
    n_tests++;
    if (dp_en !== 1'b0 || dp_din !== 16'sd250) begin
      n_fail++; $display("FAIL last_issue: got dp_en=%b dp_din=%0d want 0 250", dp_en, dp_din);
    end
    dp_resp(exp_ll);
    n_tests++;
    if (ll_valid !== 1'b1 || ll_out !== LL_W'(exp_ll)) begin
      n_fail++; $display("FAIL ramp_ll: got valid=%b ll=%0d want 1 %0d", ll_valid, ll_out, exp_ll);
    end
    n_tests++;
    if (en_lo != 250 || llv_cnt != 1 || detect !== 1'b0) begin
      n_fail++; $display("FAIL ramp_counts: got en_lo=%0d llv=%0d det=%b want 250 1 0", en_lo, llv_cnt, detect);
    end
    tick();
    n_tests++;
    if (ll_valid !== 1'b0) begin
      n_fail++; $display("FAIL llv_pulse: got %b want 0", ll_valid);
    end
  endtask

  task automatic test_detect();
    int seq [6] = '{150, 150, 90, 150, 150, 150};
    bit exp_det [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    threshold = LL_W'(100);
    restart();
    send_n(250, 1, 2);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) send_n(50, 1, 2);
      dp_resp(seq[j]);
      n_tests++;
      if (ll_valid !== 1'b1 || detect !== exp_det[j] || ll_out !== LL_W'(seq[j])) begin
        n_fail++;
        $display("FAIL detect_%0d: got valid=%b det=%b ll=%0d want 1 %b %0d",
                 j, ll_valid, detect, ll_out, exp_det[j], seq[j]);
      end
    end
  endtask

  task automatic test_timeout();
    int llv0;
    send_n(50, 1, 2);
    llv0 = llv_cnt;
    repeat (14) tick();
    n_tests++;
    if (err !== 2'b00) begin
      n_fail++; $display("FAIL tmo_early: got err=%b want 00", err);
    end
    tick();
    n_tests++;
    if (err !== 2'b10 || busy !== 1'b1 || llv_cnt != llv0) begin
      n_fail++; $display("FAIL tmo_err: got err=%b busy=%b llv=%0d want 10 1 %0d", err, busy, llv_cnt, llv0);
    end
    send_n(50, 1, 2);
    dp_resp(150);
    n_tests++;
    if (ll_valid !== 1'b1 || ll_out !== LL_W'(150) || detect !== 1'b1) begin
      n_fail++; $display("FAIL tmo_resume: got valid=%b ll=%0d det=%b want 1 150 1", ll_valid, ll_out, detect);
    end
  endtask

  task automatic test_skid();
    send_n(50, 1, 2);
    smp_valid = 1'b1; smp_in = 16'sd700;
    tick();
    smp_in = 16'sd701;
    tick();
    smp_valid = 1'b0; dp_valid = 1'b1; dp_dout = LL_W'(150);
    tick();
    dp_valid = 1'b0;
    n_tests++;
    if (ll_valid !== 1'b1 || err !== 2'b11) begin
      n_fail++; $display("FAIL skid_ovr: got valid=%b err=%b want 1 11", ll_valid, err);
    end
    tick();
    n_tests++;
    if (dp_en !== 1'b0 || dp_din !== 16'sd700) begin
      n_fail++; $display("FAIL skid_issue: got dp_en=%b dp_din=%0d want 0 700", dp_en, dp_din);
    end
    send_n(48, 1, 2);
    tick();
    dp_valid = 1'b1; dp_dout = LL_W'(999);
    tick();
    dp_valid = 1'b0;
    n_tests++;
    if (ll_valid !== 1'b0) begin
      n_fail++; $display("FAIL skid_cnt_early: got ll_valid=%b want 0", ll_valid);
    end
    send_smp(49);
    dp_resp(150);
    n_tests++;
    if (ll_valid !== 1'b1 || ll_out !== LL_W'(150)) begin
      n_fail++; $display("FAIL skid_cnt_close: got valid=%b ll=%0d want 1 150", ll_valid, ll_out);
    end
  endtask

  task automatic test_stop();
    n_tests++;
    if (detect !== 1'b1) begin
      n_fail++; $display("FAIL pre_stop_det: got %b want 1", detect);
    end
    send_n(27, 1, 2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if ({busy, dp_rst, detect, dp_en} !== 4'b0101 || err !== 2'b11 || ll_out !== LL_W'(150)) begin
      n_fail++;
      $display("FAIL stop_state: got busy,rst,det,en=%b err=%b ll=%0d want 0101 11 150",
               {busy, dp_rst, detect, dp_en}, err, ll_out);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 2'b00 || {busy, dp_rst} !== 2'b11) begin
      n_fail++; $display("FAIL start_clr: got err=%b busy,rst=%b want 00 11", err, {busy, dp_rst});
    end
    tick();
    llv_cnt = 0;
    send_n(249, 1, 2);
    tick();
    dp_valid = 1'b1; dp_dout = LL_W'(999);
    tick();
    dp_valid = 1'b0;
    n_tests++;
    if (ll_valid !== 1'b0 || llv_cnt != 0) begin
      n_fail++; $display("FAIL restart_early: got valid=%b llv=%0d want 0 0", ll_valid, llv_cnt);
    end
    send_smp(250);
    dp_resp(50);
    n_tests++;
    if (ll_valid !== 1'b1 || ll_out !== LL_W'(50) || detect !== 1'b0 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL restart_win: got valid=%b ll=%0d det=%b err=%b want 1 50 0 00", ll_valid, ll_out, detect, err);
    end
  endtask

  task automatic test_async_rst();
    send_n(50, 1, 2);
    n_tests++;
    if (busy !== 1'b1 || dp_en !== 1'b0 || ll_out !== LL_W'(50)) begin
      n_fail++; $display("FAIL pre_rst: got busy=%b dp_en=%b ll=%0d want 1 0 50", busy, dp_en, ll_out);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({dp_en, dp_rst, busy, detect, ll_valid, err} !== 7'b1100000 || dp_din !== '0 || ll_out !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got ctl=%b dp_din=%0d ll=%0d want 1100000 0 0",
               {dp_en, dp_rst, busy, detect, ll_valid, err}, dp_din, ll_out);
    end
    #9 rst = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || dp_rst !== 1'b1 || dp_en !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_idle: got busy=%b dp_rst=%b dp_en=%b want 0 1 1", busy, dp_rst, dp_en);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_detect();
    test_timeout();
    test_skid();
    test_stop();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks failed so far", n_fail, n_tests);
    $fatal(1);
  end

endmodule
